// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and the frame bit mux.
// Used by both the keyboard emulator and the board's PS/2 receiver.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        SEND_LO = 3'd2,
        GAP     = 3'd3,
        ABORT   = 3'd4
    } ps2_state_e;

    // Frame order: start(0), data[0..7], odd parity, stop(1).
    function automatic logic frame_bit(input logic [7:0] dat, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        case (idx)
            4'd0:                                    b = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:                  b = dat[3'(idx - 4'd1)];
            4'd9:                                    b = ~^dat;
            default:                                 b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ps2_keyboard_tx_if.sv
// Byte-queue handshake, inhibit and PS/2 line bundle of the keyboard emulator.
// slave = emulator side, master = the block feeding scan codes / observing the lines.
interface ps2_keyboard_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       inhibit;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       frame_done;
    logic [7:0] frames_sent;

    modport master (
        output tx_data, tx_valid, inhibit,
        input  tx_ready, ps2_clk, ps2_data, busy, frame_done, frames_sent
    );

    modport slave (
        input  tx_data, tx_valid, inhibit,
        output tx_ready, ps2_clk, ps2_data, busy, frame_done, frames_sent
    );

endinterface

// File: rtl/ps2_tx_fifo.sv
// Small synchronous byte queue with peek; full/empty come from a registered count.
// A push while full is dropped; pop is only ever issued when non-empty.
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] peek_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign peek_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)   rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_i})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: serialises queued bytes as 11-bit frames, 2 clk start latency.
// tx_ready drops when the queue is full; host inhibit aborts a frame and it is resent whole later.
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 16,
    parameter int GAP_CYCLES  = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    ps2_keyboard_tx_if.slave  bus
);

    localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int PH_W    = $clog2(MAX_CNT + 1);
    localparam logic [PH_W-1:0] HP_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e      state_q;
    logic [PH_W-1:0] phase_q;
    logic [3:0]      bit_idx_q;
    logic            ps2_clk_q;
    logic            ps2_data_q;
    logic            busy_q;
    logic            frame_done_q;
    logic [7:0]      frames_sent_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] head_dat;

    // The head byte stays in the queue for the whole frame so an aborted frame can be resent.
    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push_i     (bus.tx_valid),
        .push_dat_i (bus.tx_data),
        .pop_i      (fifo_pop),
        .peek_o     (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign fifo_pop = (state_q == SEND_LO) && (phase_q == HP_LAST) &&
                      (bit_idx_q == LAST_BIT) && !bus.inhibit;

    assign bus.tx_ready    = !fifo_full;
    assign bus.ps2_clk     = ps2_clk_q;
    assign bus.ps2_data    = ps2_data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frames_sent = frames_sent_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            bit_idx_q     <= '0;
            ps2_clk_q     <= 1'b1;
            ps2_data_q    <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !bus.inhibit) begin
                        state_q   <= SEND_HI;
                        phase_q   <= '0;
                        bit_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (bus.inhibit) begin
                        state_q    <= ABORT;
                        phase_q    <= '0;
                        bit_idx_q  <= '0;
                        ps2_clk_q  <= 1'b1;
                        ps2_data_q <= 1'b1;
                    end else if (state_q == SEND_HI) begin
                        // Data changes only right after the rising edge, well clear of the sampling edge.
                        if (phase_q == '0) ps2_data_q <= frame_bit(head_dat, bit_idx_q);
                        if (phase_q == HP_LAST) begin
                            state_q   <= SEND_LO;
                            phase_q   <= '0;
                            ps2_clk_q <= 1'b0;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end else if (phase_q == HP_LAST) begin
                        phase_q   <= '0;
                        ps2_clk_q <= 1'b1;
                        if (bit_idx_q < LAST_BIT) begin
                            state_q   <= SEND_HI;
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end else begin
                            state_q       <= GAP;
                            bit_idx_q     <= '0;
                            ps2_data_q    <= 1'b1;
                            frame_done_q  <= 1'b1;
                            frames_sent_q <= frames_sent_q + 8'd1;
                        end
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                GAP: begin
                    if (!bus.inhibit) begin
                        if (phase_q == GAP_LAST) begin
                            state_q <= IDLE;
                            phase_q <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                end
                ABORT: begin
                    if (!bus.inhibit) begin
                        state_q <= GAP;
                        phase_q <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    phase_q    <= '0;
                    bit_idx_q  <= '0;
                    ps2_clk_q  <= 1'b1;
                    ps2_data_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for the PS/2 keyboard emulator: frame bits, timing, queueing, inhibit and reset.
module tb_ps2_keyboard_tx;

    localparam int HP  = 16;
    localparam int GAP = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_keyboard_tx_if bus ();

    ps2_keyboard_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   fd_cnt   = 0;
    logic samples[$];

    // Loopback receiver: sample data on every falling PS/2 clock edge.
    always @(negedge bus.ps2_clk) samples.push_back(bus.ps2_data);
    always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, output logic acc);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        acc = bus.tx_ready;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) break;
        end
        check(tag, 32'(k < 3000), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        check(tag, 32'(k < 3000), 32'd1);
    endtask

    task automatic wait_samples(input string tag, input int n);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (samples.size() >= n) break;
        end
        check(tag, 32'(k < 3000), 32'd1);
    endtask

    // Sample i of the frame lands in bit i of the packed value.
    task automatic check_frame(input string tag, input logic [10:0] exp);
        logic [10:0] v;
        v = '0;
        check({tag, "_len"}, 32'(samples.size() >= 11), 32'd1);
        for (int i = 0; i < 11; i++)
            if (samples.size() > 0) v[i] = samples.pop_front();
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic measure_gap(input string tag);
        int run;
        for (run = 0; run < 500; run++) begin
            if (!(bus.ps2_clk === 1'b1 && bus.ps2_data === 1'b1)) break;
            @(negedge clk);
        end
        check(tag, 32'(run >= GAP && run < 500), 32'd1);
    endtask

    logic acc;
    logic acc_v[5];
    int   lat, dur, fd0, k;

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.inhibit  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_clk",   32'(bus.ps2_clk),     32'd1);
        check("rst_data",  32'(bus.ps2_data),    32'd1);
        check("rst_ready", 32'(bus.tx_ready),    32'd1);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_fd",    32'(bus.frame_done),  32'd0);
        check("rst_cnt",   32'(bus.frames_sent), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single 0x1C frame, start latency
        fd0 = fd_cnt;
        push(8'h1C, acc);
        check("t1_acc", 32'(acc), 32'd1);
        for (lat = 0; lat < 10; lat++) begin
            @(negedge clk);
            if (bus.ps2_data === 1'b0) break;
        end
        check("t1_latency", 32'(lat), 32'd2);
        wait_fd("t1_done");
        wait_idle("t1_idle");
        check("t1_fd_pulses", 32'(fd_cnt - fd0), 32'd1);
        check_frame("t1_bits", 11'h438);
        check("t1_cnt", 32'(bus.frames_sent), 32'd1);

        // 2: 0x00 has parity 1; frame is 22 half periods long
        push(8'h00, acc);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) break;
        end
        for (dur = 1; dur < 1000; dur++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) break;
        end
        check("t2_duration", 32'(dur), 32'(22 * HP));
        check("t2_edges", 32'(samples.size()), 32'd11);
        check("t2_parity", 32'(samples[9]), 32'd1);
        check_frame("t2_bits", 11'h600);
        wait_idle("t2_idle");
        check("t2_cnt", 32'(bus.frames_sent), 32'd2);

        // 3: back-to-back bytes, gaps between frames
        push(8'h1C, acc_v[0]);
        push(8'hF0, acc_v[1]);
        push(8'h1C, acc_v[2]);
        check("t3_acc", 32'({acc_v[0], acc_v[1], acc_v[2]}), 32'h7);
        wait_fd("t3_f1");
        measure_gap("t3_gap1");
        wait_fd("t3_f2");
        measure_gap("t3_gap2");
        wait_fd("t3_f3");
        check_frame("t3_b1", 11'h438);
        check_frame("t3_b2", 11'h7E0);
        check_frame("t3_b3", 11'h438);
        wait_idle("t3_idle");
        check("t3_cnt", 32'(bus.frames_sent), 32'd5);

        // 4: inhibit held, queue fills at four bytes
        @(negedge clk) bus.inhibit = 1'b1;
        push(8'h1C, acc_v[0]);
        push(8'h00, acc_v[1]);
        push(8'hF0, acc_v[2]);
        push(8'h2A, acc_v[3]);
        push(8'h55, acc_v[4]);
        check("t4_acc", 32'({acc_v[0], acc_v[1], acc_v[2], acc_v[3], acc_v[4]}), 32'h1E);
        @(negedge clk);
        check("t4_ready", 32'(bus.tx_ready), 32'd0);
        repeat (100) @(negedge clk);
        check("t4_no_edges", 32'(samples.size()), 32'd0);
        check("t4_clk_high", 32'(bus.ps2_clk), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        bus.inhibit = 1'b0;
        wait_fd("t4_f1");
        wait_fd("t4_f2");
        wait_fd("t4_f3");
        wait_fd("t4_f4");
        check_frame("t4_b1", 11'h438);
        check_frame("t4_b2", 11'h600);
        check_frame("t4_b3", 11'h7E0);
        check_frame("t4_b4", 11'h454);
        wait_idle("t4_idle");
        check("t4_cnt", 32'(bus.frames_sent), 32'd9);

        // 5: inhibit during bit 5 of 0x2A aborts, then the frame is resent whole
        fd0 = fd_cnt;
        push(8'h2A, acc);
        wait_samples("t5_reach", 5);
        repeat (HP + 4) @(negedge clk);
        bus.inhibit = 1'b1;
        @(negedge clk);
        check("t5_abort_clk",  32'(bus.ps2_clk),  32'd1);
        check("t5_abort_data", 32'(bus.ps2_data), 32'd1);
        repeat (50) @(negedge clk);
        check("t5_partial", 32'(samples.size()), 32'd5);
        check("t5_busy", 32'(bus.busy), 32'd1);
        check("t5_no_fd", 32'(fd_cnt - fd0), 32'd0);
        check("t5_cnt_hold", 32'(bus.frames_sent), 32'd9);
        samples.delete();
        bus.inhibit = 1'b0;
        wait_fd("t5_resend");
        check_frame("t5_bits", 11'h454);
        wait_idle("t5_idle");
        check("t5_fd_once", 32'(fd_cnt - fd0), 32'd1);
        check("t5_cnt", 32'(bus.frames_sent), 32'd10);

        // 6: reset mid-frame clears everything, queued bytes are lost
        push(8'hF0, acc);
        push(8'h1C, acc);
        wait_samples("t6_reach", 3);
        repeat (HP + 4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_clk",   32'(bus.ps2_clk),     32'd1);
        check("t6_data",  32'(bus.ps2_data),    32'd1);
        check("t6_busy",  32'(bus.busy),        32'd0);
        check("t6_ready", 32'(bus.tx_ready),    32'd1);
        check("t6_cnt",   32'(bus.frames_sent), 32'd0);
        check("t6_fd",    32'(bus.frame_done),  32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        samples.delete();
        repeat (600) @(negedge clk);
        check("t6_no_edges", 32'(samples.size()), 32'd0);
        check("t6_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
